// File: rtl/even_counter_sequencer_if.sv
// Control/status bundle for the parity step counter sequencer.
interface even_counter_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             hold;
  logic [1:0]       mode;
  logic             dir;
  logic             auto_reload;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output start, stop, hold, mode, dir, auto_reload, limit,
    input  count, busy, done, wrap
  );

  modport slave (
    input  start, stop, hold, mode, dir, auto_reload, limit,
    output count, busy, done, wrap
  );
endinterface

// File: rtl/even_counter_sequencer.sv
// Parity step counter sequencer: latches a run config on start and steps the
// count between a parity-aligned base and terminal, one-shot or auto-reload.
module even_counter_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  even_counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  // Latched run configuration
  logic [WIDTH-1:0] first_q, term_q, step_q;
  logic             dir_q, auto_q;
  logic             cfg_load;

  // Decoded configuration from the live inputs
  logic             odd_sel, even_sel, cfg_valid;
  logic [WIDTH-1:0] new_lo, new_hi, new_step, new_first, new_term;

  always_comb begin
    odd_sel   = (bus.mode == 2'b10);
    even_sel  = (bus.mode == 2'b01);
    new_lo    = odd_sel ? WIDTH'(1) : '0;
    new_step  = (odd_sel || even_sel) ? WIDTH'(2) : WIDTH'(1);
    cfg_valid = !(odd_sel && (bus.limit == '0));
    if (even_sel) begin
      new_hi = {bus.limit[WIDTH-1:1], 1'b0};
    end else if (odd_sel) begin
      new_hi = bus.limit[0] ? bus.limit : (bus.limit - WIDTH'(1));
    end else begin
      new_hi = bus.limit;
    end
    new_first = bus.dir ? new_hi : new_lo;
    new_term  = bus.dir ? new_lo : new_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= '0;
      term_q  <= '0;
      step_q  <= WIDTH'(1);
      dir_q   <= 1'b0;
      auto_q  <= 1'b0;
    end else if (cfg_load) begin
      first_q <= new_first;
      term_q  <= new_term;
      step_q  <= new_step;
      dir_q   <= bus.dir;
      auto_q  <= bus.auto_reload;
    end
  end

  // Priority within RUN/HOLD: stop, then hold, then terminal/advance.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    cfg_load = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start && cfg_valid) begin
          state_d  = RUN;
          count_d  = new_first;
          cfg_load = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.hold) begin
          state_d = HOLD;
        end else if (count_q == term_q) begin
          if (auto_q) begin
            count_d = first_q;
            wrap_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          count_d = dir_q ? (count_q - step_q) : (count_q + step_q);
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (!bus.hold) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN) || (state_q == HOLD);
  assign bus.done  = done_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_even_counter_sequencer.sv
// Directed plus randomized bench for even_counter_sequencer against a
// sequence-list reference model.
module tb_even_counter_sequencer;

  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  even_counter_sequencer_if #(.WIDTH(WIDTH)) bus ();

  even_counter_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the whole run is precomputed as a list of values and
  // the model walks an index through it.
  int m_seq[$];
  int m_idx;
  int m_count;
  bit m_busy, m_held, m_auto, m_done, m_wrap;

  function automatic bit cfg_ok(input int md, input int lim);
    return !(md == 2 && lim == 0);
  endfunction

  function automatic void build_seq(input int md, input int dr, input int lim);
    int lo, hi, st;
    int tmp[$];
    lo = (md == 2) ? 1 : 0;
    st = (md == 1 || md == 2) ? 2 : 1;
    if (md == 1)      hi = lim - (lim % 2);
    else if (md == 2) hi = (lim % 2 == 1) ? lim : lim - 1;
    else              hi = lim;
    for (int v = lo; v <= hi; v += st) tmp.push_back(v);
    m_seq.delete();
    if (dr != 0) begin
      for (int i = tmp.size() - 1; i >= 0; i--) m_seq.push_back(tmp[i]);
    end else begin
      m_seq = tmp;
    end
  endfunction

  function automatic void model_edge();
    m_done = 0;
    m_wrap = 0;
    if (rst) begin
      m_count = 0;
      m_busy  = 0;
      m_held  = 0;
    end else if (m_busy) begin
      if (bus.stop) begin
        m_busy = 0;
        m_held = 0;
      end else if (bus.hold) begin
        m_held = 1;
      end else if (m_held) begin
        m_held = 0;
      end else if (m_idx == m_seq.size() - 1) begin
        if (m_auto) begin
          m_idx   = 0;
          m_count = m_seq[0];
          m_wrap  = 1;
        end else begin
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        m_idx++;
        m_count = m_seq[m_idx];
      end
    end else if (bus.start && cfg_ok(int'(bus.mode), int'(bus.limit))) begin
      build_seq(int'(bus.mode), int'(bus.dir), int'(bus.limit));
      m_auto  = bus.auto_reload;
      m_idx   = 0;
      m_count = m_seq[0];
      m_busy  = 1;
      m_held  = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("count", {28'd0, bus.count}, m_count);
    chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
    chk("done", {31'd0, bus.done}, {31'd0, m_done});
    chk("wrap", {31'd0, bus.wrap}, {31'd0, m_wrap});
  endtask

  task automatic run_until(input int v, input int maxc, input string tag);
    int n = 0;
    while (m_count != v && n < maxc) begin
      cyc();
      n++;
    end
    chk(tag, {28'd0, bus.count}, v);
  endtask

  task automatic run_to_end(input int maxc, input string tag);
    int n = 0;
    while (m_busy && n < maxc) begin
      cyc();
      n++;
    end
    chk(tag, {31'd0, bus.busy}, 0);
  endtask

  task automatic set_cfg(input int md, input int dr, input int ar, input int lim);
    bus.mode        = 2'(md);
    bus.dir         = 1'(dr);
    bus.auto_reload = 1'(ar);
    bus.limit       = WIDTH'(lim);
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.hold = 0;
    set_cfg(0, 0, 0, 0);
    m_count = 0; m_busy = 0; m_held = 0; m_auto = 0; m_idx = 0;

    // Reset
    rst = 1;
    cyc(); cyc();
    chk("rst_count", {28'd0, bus.count}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    rst = 0;

    // 1: even up one-shot, limit 9 -> 0,2,4,6,8 then done
    set_cfg(1, 0, 0, 9); bus.start = 1;
    cyc(); bus.start = 0;
    chk("t1_first", {28'd0, bus.count}, 0);
    run_to_end(20, "t1_timeout");
    chk("t1_done", {31'd0, bus.done}, 1);
    chk("t1_term", {28'd0, bus.count}, 8);
    cyc();
    chk("t1_done_pulse", {31'd0, bus.done}, 0);
    chk("t1_hold_term", {28'd0, bus.count}, 8);

    // 2: odd down auto-reload, limit 15
    set_cfg(2, 1, 1, 15); bus.start = 1;
    cyc(); bus.start = 0;
    chk("t2_first", {28'd0, bus.count}, 15);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      if (i == 7) chk("t2_low", {28'd0, bus.count}, 1);
      if (i == 8) begin
        chk("t2_wrap", {31'd0, bus.wrap}, 1);
        chk("t2_reload", {28'd0, bus.count}, 15);
      end
    end
    chk("t2_after", {28'd0, bus.count}, 13);
    bus.stop = 1; cyc(); bus.stop = 0;

    // 3: even up limit 14 with a 3-cycle hold at 6
    set_cfg(1, 0, 0, 14); bus.start = 1;
    cyc(); bus.start = 0;
    run_until(6, 20, "t3_reach6");
    bus.hold = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_frozen", {28'd0, bus.count}, 6);
      chk("t3_busy", {31'd0, bus.busy}, 1);
    end
    bus.hold = 0;
    cyc();
    cyc();
    chk("t3_resume", {28'd0, bus.count}, 8);
    run_to_end(20, "t3_timeout");
    chk("t3_term", {28'd0, bus.count}, 14);
    chk("t3_done", {31'd0, bus.done}, 1);

    // 4: all up limit 7, stop at 4, restart
    set_cfg(0, 0, 0, 7); bus.start = 1;
    cyc(); bus.start = 0;
    run_until(4, 20, "t4_reach4");
    bus.stop = 1; cyc(); bus.stop = 0;
    chk("t4_stop_count", {28'd0, bus.count}, 4);
    chk("t4_stop_busy", {31'd0, bus.busy}, 0);
    chk("t4_stop_done", {31'd0, bus.done}, 0);
    cyc();
    bus.start = 1; cyc(); bus.start = 0;
    chk("t4_restart", {28'd0, bus.count}, 0);
    bus.stop = 1; cyc(); bus.stop = 0;

    // 5: invalid odd/limit 0 ignored; all/limit 0 single value
    set_cfg(2, 0, 0, 0); bus.start = 1;
    cyc(); bus.start = 0;
    chk("t5_ignored_busy", {31'd0, bus.busy}, 0);
    chk("t5_ignored_count", {28'd0, bus.count}, 0);
    set_cfg(0, 0, 0, 0); bus.start = 1;
    cyc(); bus.start = 0;
    chk("t5_single_busy", {31'd0, bus.busy}, 1);
    cyc();
    chk("t5_single_done", {31'd0, bus.done}, 1);
    chk("t5_single_count", {28'd0, bus.count}, 0);

    // 6: rst mid-run with start held, then relaunch
    set_cfg(1, 0, 0, 14); bus.start = 1;
    cyc(); bus.start = 0;
    run_until(10, 20, "t6_reach10");
    bus.start = 1; rst = 1;
    cyc();
    chk("t6_rst_count", {28'd0, bus.count}, 0);
    chk("t6_rst_busy", {31'd0, bus.busy}, 0);
    rst = 0;
    cyc(); bus.start = 0;
    chk("t6_relaunch_busy", {31'd0, bus.busy}, 1);
    chk("t6_relaunch_count", {28'd0, bus.count}, 0);

    // Randomized traffic, config inputs churning every cycle
    for (int i = 0; i < 600; i++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 15));
      bus.start = m_busy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      bus.hold  = ($urandom_range(0, 5) == 0);
      bus.stop  = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 0; bus.start = 0; bus.hold = 0; bus.stop = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/even_counter_sequencer.md
Name: even_counter_sequencer

Overview:
Controller for the team's parity step counters (all/even/odd sequences). It latches a run configuration on a start pulse and sequences the count between a parity-aligned base and terminal value. The sequence can run up or down, and either one-shot or auto-reload. It supports hold, pause/resume and abort, and reports busy/done/wrap status. It sits between a control FSM or testbench and any consumer of the count value.

Parameters:
WIDTH, 4, width of count and limit.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a run; sampled only in IDLE or DONE.
stop  input  1  abort run; sampled in RUN/HOLD.
hold  input  1  freeze count while high; sampled in RUN/HOLD.
mode  input  2  00 all (step 1), 01 even (step 2), 10 odd (step 2), 11 reserved (treated as 00).
dir  input  1  0 up, 1 down.
auto_reload  input  1  1 = continuous wrap, 0 = one-shot.
limit  input  WIDTH  upper bound of sequence (inclusive).
count  output  WIDTH  current sequence value (registered).
busy  output  1  high in RUN and HOLD.
done  output  1  one-cycle pulse on one-shot completion.
wrap  output  1  one-cycle pulse when the count reloads in auto_reload.

Behaviour:
- States: IDLE, RUN, HOLD, DONE. Reset: state IDLE, count 0, busy 0, done 0, wrap 0. rst overrides all other inputs, including mid-run.
- Config (mode, dir, auto_reload, limit) is latched on an accepted start. Input changes during a run have no effect.
- lo = 1 for odd, else 0.
- hi = limit for all. For even, hi = limit with LSB cleared. For odd, hi = limit with LSB set, or limit-1 if limit is even.
- Up: first = lo, term = hi. Down: first = hi, term = lo.
- Invalid config: odd mode with limit 0. An accepted start with invalid config is ignored; state and count are unchanged.
- IDLE/DONE + start (valid): next edge count = first, state RUN, busy 1. Latency from start to first value is 1 clock.
- RUN, hold=0, count != term: next edge count = count ± step.
- RUN, count == term, auto_reload=1: next edge count = first; wrap=1 for that cycle only.
- RUN, count == term, auto_reload=0: next edge state DONE, count holds term, busy 0, done=1 for one cycle.
- first == term (e.g. all mode, limit 0): RUN shows that value for one cycle, then completes or wraps per the RUN rules above.
- RUN + hold=1: count does not advance on that edge; state HOLD.
- HOLD + hold=1: count stays frozen.
- HOLD + hold=0: state RUN; advance resumes on the following edge.
- Terminal detection applies only in RUN with hold=0.
- stop in RUN or HOLD: next edge state IDLE, count holds its current value, busy 0, no done.
- Priority: rst > stop > hold > terminal/advance.
- start in RUN or HOLD is ignored.
- DONE persists, holding count, until start (restart) or rst. done is a pulse and does not track the state.
- Arithmetic: count never exceeds limit and never goes below lo. Step arithmetic is WIDTH bits; the terminal compare prevents overflow.

Test Plan:
1. rst 2 cycles; start with mode=01, dir=0, auto_reload=0, limit=9 -> count 0,2,4,6,8. Then done=1 for one cycle, busy 0, count holds 8.
2. mode=10, dir=1, auto_reload=1, limit=15 -> count 15,13,11,...,1,15,13. wrap=1 only in the cycle count returns to 15; done never asserts.
3. mode=01, up, limit=14; hold=1 for 3 cycles when count=6 -> count stays 6 in those cycles and the state is HOLD. After hold drops, count continues 8,10,12,14, then done.
4. mode=00, up, limit=7; stop when count=4 -> IDLE next edge, count 4, busy 0, no done. A new start restarts from 0.
5. mode=10, limit=0, start -> ignored: busy 0, count unchanged. mode=00, limit=0, start -> count 0 for one cycle, then done.
6. mode=01, up, limit=14; rst asserted with count=10 and start held high -> next edge count 0, busy 0, state IDLE. Once rst drops, the still-high start launches a new run from 0.
